// File: rtl/sm_input_conditioner.sv
// Front end for the 2-bit state-machine stage: synchronises the raw
// switches, debounces PBC and produces a single-domain STEP enable.
// Ports: CLK, RST_N (async active-low); X_IN[2:0], MODE_IN, PBC raw in;
// X_OUT[2:0] synced switches, PBC_LEVEL/PBC_PULSE debounced button,
// STEP one-cycle advance enable, HEARTBEAT tick toggle for an LED.
module sm_input_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_COUNT    = 1000000,
   parameter int DB_WIDTH    = 20,
   parameter int TICK_DIV    = 50000000,
   parameter int TICK_WIDTH  = 26
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [2:0] X_IN,
   input  logic       MODE_IN,
   input  logic       PBC,
   output logic [2:0] X_OUT,
   output logic       PBC_LEVEL,
   output logic       PBC_PULSE,
   output logic       STEP,
   output logic       HEARTBEAT
);

   typedef enum logic [1:0] {
      LOW,
      WAIT_HIGH,
      HIGH,
      WAIT_LOW
   } db_state_t;

   localparam logic [DB_WIDTH-1:0] DB_LAST =
      DB_WIDTH'(DB_COUNT - 1);
   localparam logic [TICK_WIDTH-1:0] TICK_LAST =
      TICK_WIDTH'(TICK_DIV - 1);

   // bundle order per stage: {x3,x2,x1, mode, pbc}
   logic [SYNC_STAGES-1:0][4:0] sync_q;
   logic                        mode_s;
   logic                        pbc_s;

   db_state_t             state_q, state_d;
   logic [DB_WIDTH-1:0]   db_cnt_q, db_cnt_d;
   logic                  level_d;
   logic                  pulse_d;

   logic [TICK_WIDTH-1:0] tick_q;
   logic                  tick;
   logic                  step_src;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= {X_IN, MODE_IN, PBC};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign {X_OUT, mode_s, pbc_s} = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d  = state_q;
      db_cnt_d = db_cnt_q;
      level_d  = PBC_LEVEL;
      pulse_d  = 1'b0;
      unique case (state_q)
         LOW: begin
            if (pbc_s) state_d = WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (!pbc_s) begin
               state_d  = LOW;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = HIGH;
               db_cnt_d = '0;
               level_d  = 1'b1;
               pulse_d  = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         HIGH: begin
            if (!pbc_s) state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (pbc_s) begin
               state_d  = HIGH;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = LOW;
               db_cnt_d = '0;
               level_d  = 1'b0;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d  = LOW;
            db_cnt_d = '0;
            level_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= LOW;
         db_cnt_q  <= '0;
         PBC_LEVEL <= 1'b0;
         PBC_PULSE <= 1'b0;
      end else begin
         state_q   <= state_d;
         db_cnt_q  <= db_cnt_d;
         PBC_LEVEL <= level_d;
         PBC_PULSE <= pulse_d;
      end
   end

   assign tick = (tick_q == TICK_LAST);

   // only the active mode's source can fire; the ~STEP term keeps
   // STEP from ever being high two cycles running
   assign step_src = mode_s ? PBC_PULSE : (tick & PBC_LEVEL);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tick_q    <= '0;
         HEARTBEAT <= 1'b0;
         STEP      <= 1'b0;
      end else begin
         tick_q    <= tick ? '0 : tick_q + 1'b1;
         HEARTBEAT <= HEARTBEAT ^ tick;
         STEP      <= step_src & ~STEP;
      end
   end

endmodule

// File: tb/tb_sm_input_conditioner.sv
// Directed bench for sm_input_conditioner with small counts
// (SYNC_STAGES=2, DB_COUNT=4, TICK_DIV=8).
module tb_sm_input_conditioner;

   localparam logic I = 1'b1;
   localparam logic O = 1'b0;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [2:0] X_IN = 3'd0;
   logic       MODE_IN = 1'b0;
   logic       PBC = 1'b0;
   logic [2:0] X_OUT;
   logic       PBC_LEVEL;
   logic       PBC_PULSE;
   logic       STEP;
   logic       HEARTBEAT;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   typedef struct {
      logic [2:0] x;
      logic       mode;
      logic       pbc;
      logic [2:0] ex;
      logic       el;
      logic       ep;
      logic       es;
      logic       eh;
   } vec_t;

   vec_t v [24];

   sm_input_conditioner #(
      .SYNC_STAGES(2),
      .DB_COUNT(4),
      .DB_WIDTH(3),
      .TICK_DIV(8),
      .TICK_WIDTH(4)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .X_IN(X_IN),
      .MODE_IN(MODE_IN),
      .PBC(PBC),
      .X_OUT(X_OUT),
      .PBC_LEVEL(PBC_LEVEL),
      .PBC_PULSE(PBC_PULSE),
      .STEP(STEP),
      .HEARTBEAT(HEARTBEAT)
   );

   always #5 CLK = ~CLK;

   task automatic clk_step();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic chk3(input string nm, input logic [2:0] act,
                       input logic [2:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act,
                       input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] ex,
                          input logic el, input logic ep,
                          input logic es, input logic eh);
      chk3({tag, ".x_out"}, X_OUT, ex);
      chk1({tag, ".level"}, PBC_LEVEL, el);
      chk1({tag, ".pulse"}, PBC_PULSE, ep);
      chk1({tag, ".step"}, STEP, es);
      chk1({tag, ".heartbeat"}, HEARTBEAT, eh);
   endtask

   initial begin
      // clean press and switch change in MODE=1, from reset release
      v[0]  = '{3'd5, I, O, 3'd0, O, O, O, O};
      v[1]  = '{3'd5, I, O, 3'd5, O, O, O, O};
      v[2]  = '{3'd5, I, O, 3'd5, O, O, O, O};
      v[3]  = '{3'd5, I, I, 3'd5, O, O, O, O};
      v[4]  = '{3'd5, I, I, 3'd5, O, O, O, O};
      v[5]  = '{3'd5, I, I, 3'd5, O, O, O, O};
      v[6]  = '{3'd5, I, I, 3'd5, O, O, O, O};
      v[7]  = '{3'd5, I, I, 3'd5, O, O, O, I};
      v[8]  = '{3'd5, I, I, 3'd5, O, O, O, I};
      v[9]  = '{3'd5, I, I, 3'd5, I, I, O, I};
      v[10] = '{3'd5, I, I, 3'd5, I, O, I, I};
      v[11] = '{3'd5, I, I, 3'd5, I, O, O, I};
      v[12] = '{3'd2, I, I, 3'd5, I, O, O, I};
      v[13] = '{3'd2, I, I, 3'd2, I, O, O, I};
      v[14] = '{3'd2, I, O, 3'd2, I, O, O, I};
      v[15] = '{3'd2, I, O, 3'd2, I, O, O, O};
      v[16] = '{3'd2, I, O, 3'd2, I, O, O, O};
      v[17] = '{3'd2, I, O, 3'd2, I, O, O, O};
      v[18] = '{3'd2, I, O, 3'd2, I, O, O, O};
      v[19] = '{3'd2, I, O, 3'd2, I, O, O, O};
      v[20] = '{3'd2, I, O, 3'd2, O, O, O, O};
      v[21] = '{3'd2, I, O, 3'd2, O, O, O, O};
      v[22] = '{3'd2, I, O, 3'd2, O, O, O, O};
      v[23] = '{3'd2, I, O, 3'd2, O, O, O, I};

      // reset held while every input toggles
      for (int k = 0; k < 5; k++) begin
         X_IN    = 3'(k + 3);
         MODE_IN = k[0];
         PBC     = ~k[0];
         clk_step();
         chk_all("rst_hold", 3'd0, O, O, O, O);
      end

      RST_N = 1'b1;
      cyc = 0;
      for (int i = 0; i < 24; i++) begin
         X_IN    = v[i].x;
         MODE_IN = v[i].mode;
         PBC     = v[i].pbc;
         clk_step();
         chk_all($sformatf("vec%0d", i), v[i].ex, v[i].el,
                 v[i].ep, v[i].es, v[i].eh);
      end

      // bounce in MODE=1: a 3-cycle burst must be rejected
      begin
         logic [7:0] pat;
         int np, ns;
         pat = 8'b1111_0111;
         np = 0;
         ns = 0;
         for (int k = 0; k < 15; k++) begin
            PBC = (k < 8) ? pat[k] : 1'b1;
            clk_step();
            chk1("bounce.level", PBC_LEVEL, k >= 10);
            chk1("bounce.pulse", PBC_PULSE, k == 10);
            chk1("bounce.step", STEP, k == 11);
            np += int'(PBC_PULSE);
            ns += int'(STEP);
         end
         n_cmp++;
         if (np != 1 || ns != 1) begin
            n_bad++;
            $display("FAIL bounce.count pulses=%0d steps=%0d want 1/1",
                     np, ns);
         end
         PBC = 1'b0;
         for (int j = 0; j < 8; j++) begin
            clk_step();
            chk1("bounce_rel.level", PBC_LEVEL, j < 6);
            chk1("bounce_rel.step", STEP, O);
         end
      end

      // free-run MODE=0 from a fresh reset, button held 40 cycles
      #2;
      RST_N = 1'b0;
      #1;
      chk_all("async_rst", 3'd0, O, O, O, O);
      MODE_IN = 1'b0;
      PBC = 1'b0;
      clk_step();
      clk_step();
      RST_N = 1'b1;
      PBC = 1'b1;
      cyc = 0;
      for (int n = 1; n <= 119; n++) begin
         if (n == 41)  PBC = 1'b0;
         if (n == 57)  PBC = 1'b1;
         if (n == 70)  MODE_IN = 1'b1;
         if (n == 81)  PBC = 1'b0;
         if (n == 91)  PBC = 1'b1;
         if (n == 106) PBC = 1'b0;
         if (n == 116) PBC = 1'b1;
         clk_step();
         chk1("run.heartbeat", HEARTBEAT, ((n / 8) % 2) == 1);
         chk1("run.level", PBC_LEVEL,
              (n >= 7 && n <= 46) || (n >= 63 && n <= 86) ||
              (n >= 97 && n <= 111));
         chk1("run.pulse", PBC_PULSE, n == 7 || n == 63 || n == 97);
         chk1("run.step", STEP,
              (n % 8 == 0 && n >= 8 && n <= 40) || n == 64 || n == 98);
      end

      // reset in the middle of a debounce count, button kept high
      RST_N = 1'b0;
      #1;
      chk_all("mid_rst", 3'd0, O, O, O, O);
      clk_step();
      clk_step();
      chk_all("mid_rst_hold", 3'd0, O, O, O, O);
      RST_N = 1'b1;
      cyc = 0;
      for (int n = 1; n <= 10; n++) begin
         clk_step();
         chk_all($sformatf("recount%0d", n),
                 (n >= 2) ? 3'd2 : 3'd0, n >= 7, n == 7,
                 n == 8, n >= 8);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
